// File: rtl/msrv_32_dmem_slave.sv
// msrv_32_dmem_slave: word-organised data memory responder for the MSRV32 core.
// Requests are accepted while hready is high, held for WAIT_STATES stall cycles,
// then answered in a single RESP cycle that carries read data or the error flag.
// Optional feature macro: MSRV32_DMEM_BOUNDS_CHK_EN (out-of-range word index is
// reported on herr instead of wrapping modulo DEPTH_WORDS).
module msrv_32_dmem_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic        ms_riscv32_mp_dmrd_req_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ms_riscv32_mp_hready_out,
  output logic        ms_riscv32_mp_herr_out
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  lat_mask;
  logic        lat_wr;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic [3:0]  sel_mask;
  logic        sel_wr;
  logic [31:0] sel_off;
  logic [29:0] sel_word;
  logic [AW-1:0] sel_idx;
  logic        sel_err;
  logic [31:0] rd_word;
  logic        unused_bits;

  // Pick the access being completed: the latched one while stalling, or the live
  // request when a zero-wait-state slave enters RESP on the accept edge itself.
  always_comb begin
    accept = ms_riscv32_mp_hready_out &
             (ms_riscv32_mp_dmwr_req_in | ms_riscv32_mp_dmrd_req_in);
    if (state == WAIT) begin
      sel_addr = lat_addr;
      sel_data = lat_data;
      sel_mask = lat_mask;
      sel_wr   = lat_wr;
      commit   = (wait_cnt == 4'd0);
    end else begin
      sel_addr = ms_riscv32_mp_dmaddr_in;
      sel_data = ms_riscv32_mp_dmdata_in;
      sel_mask = ms_riscv32_mp_dmwr_mask_in;
      sel_wr   = ms_riscv32_mp_dmwr_req_in;
      commit   = accept && (WAIT_STATES == 0);
    end
    sel_off  = sel_addr - BASE_ADDR;
    sel_word = sel_off[31:2];
    sel_idx  = sel_word[AW-1:0];
  end

`ifdef MSRV32_DMEM_BOUNDS_CHK_EN
  assign sel_err = (sel_word >= 30'(DEPTH_WORDS));
`else
  assign sel_err = 1'b0;
`endif

  assign rd_word     = mem[sel_idx];
  assign unused_bits = ^{sel_off[1:0], sel_word};

  // Handshake FSM: accept in IDLE/RESP, stall in WAIT, present the result in RESP.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                    <= IDLE;
      wait_cnt                 <= 4'd0;
      lat_addr                 <= 32'd0;
      lat_data                 <= 32'd0;
      lat_mask                 <= 4'd0;
      lat_wr                   <= 1'b0;
      ms_riscv32_mp_dmdata_out <= 32'd0;
      ms_riscv32_mp_hready_out <= 1'b1;
      ms_riscv32_mp_herr_out   <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= ms_riscv32_mp_dmaddr_in;
        lat_data <= ms_riscv32_mp_dmdata_in;
        lat_mask <= ms_riscv32_mp_dmwr_mask_in;
        lat_wr   <= ms_riscv32_mp_dmwr_req_in;
      end
      if (commit) begin
        state                    <= RESP;
        ms_riscv32_mp_hready_out <= 1'b1;
        ms_riscv32_mp_herr_out   <= sel_err;
        ms_riscv32_mp_dmdata_out <= (!sel_wr && !sel_err) ? rd_word : 32'd0;
      end else if (state == WAIT) begin
        wait_cnt                 <= wait_cnt - 4'd1;
        ms_riscv32_mp_dmdata_out <= 32'd0;
        ms_riscv32_mp_herr_out   <= 1'b0;
      end else if (accept) begin
        state                    <= WAIT;
        wait_cnt                 <= 4'(WAIT_STATES - 1);
        ms_riscv32_mp_hready_out <= 1'b0;
        ms_riscv32_mp_dmdata_out <= 32'd0;
        ms_riscv32_mp_herr_out   <= 1'b0;
      end else begin
        state                    <= IDLE;
        ms_riscv32_mp_hready_out <= 1'b1;
        ms_riscv32_mp_dmdata_out <= 32'd0;
        ms_riscv32_mp_herr_out   <= 1'b0;
      end
    end
  end

  // Masked byte write on the edge that enters RESP; reset on that edge cancels it.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in && commit && sel_wr && !sel_err) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_mask[b]) begin
          mem[sel_idx][8*b +: 8] <= sel_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_msrv_32_dmem_slave.sv
// tb_msrv_32_dmem_slave: three slaves (0, 1 and 3 wait states, one at a high
// base address) driven with directed and random accesses and compared against
// a per-instance array model of the memory.
module tb_msrv_32_dmem_slave;

  logic        clk = 1'b0;
  logic        rst_n   [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [3:0]  mask_s  [3];
  logic        wr_s    [3];
  logic        rd_s    [3];
  logic [31:0] rdata_s [3];
  logic        hready_s[3];
  logic        herr_s  [3];

  int tests_run    = 0;
  int tests_failed = 0;
  bit bounds_chk;

  logic [31:0] model_mem [3][1024];
  bit          model_vld [3][1024];

  // Free-running clock shared by all three instances.
  always #5 clk = ~clk;

  msrv_32_dmem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_ws0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n[0]),
    .ms_riscv32_mp_dmaddr_in(addr_s[0]), .ms_riscv32_mp_dmdata_in(wdata_s[0]),
    .ms_riscv32_mp_dmwr_mask_in(mask_s[0]), .ms_riscv32_mp_dmwr_req_in(wr_s[0]),
    .ms_riscv32_mp_dmrd_req_in(rd_s[0]), .ms_riscv32_mp_dmdata_out(rdata_s[0]),
    .ms_riscv32_mp_hready_out(hready_s[0]), .ms_riscv32_mp_herr_out(herr_s[0]));

  msrv_32_dmem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u_ws1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n[1]),
    .ms_riscv32_mp_dmaddr_in(addr_s[1]), .ms_riscv32_mp_dmdata_in(wdata_s[1]),
    .ms_riscv32_mp_dmwr_mask_in(mask_s[1]), .ms_riscv32_mp_dmwr_req_in(wr_s[1]),
    .ms_riscv32_mp_dmrd_req_in(rd_s[1]), .ms_riscv32_mp_dmdata_out(rdata_s[1]),
    .ms_riscv32_mp_hready_out(hready_s[1]), .ms_riscv32_mp_herr_out(herr_s[1]));

  msrv_32_dmem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h8000_0000)) u_ws3 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n[2]),
    .ms_riscv32_mp_dmaddr_in(addr_s[2]), .ms_riscv32_mp_dmdata_in(wdata_s[2]),
    .ms_riscv32_mp_dmwr_mask_in(mask_s[2]), .ms_riscv32_mp_dmwr_req_in(wr_s[2]),
    .ms_riscv32_mp_dmrd_req_in(rd_s[2]), .ms_riscv32_mp_dmdata_out(rdata_s[2]),
    .ms_riscv32_mp_hready_out(hready_s[2]), .ms_riscv32_mp_herr_out(herr_s[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: word index from the byte offset, optional range error,
  // byte-merge on writes, stored word returned on reads.
  task automatic model_access(input int d, input bit is_wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] mask,
                              output logic exp_err, output logic [31:0] exp_data,
                              output bit known);
    logic [31:0] word;
    int idx;
    word = (addr - base_of(d)) / 4;
    exp_err  = 1'b0;
    exp_data = 32'd0;
    known    = 1'b1;
    if (bounds_chk && word >= 32'd1024) begin
      exp_err = 1'b1;
      return;
    end
    idx = int'(word % 32'd1024);
    if (is_wr) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) model_mem[d][idx][8*b +: 8] = data[8*b +: 8];
      if (mask == 4'hF) model_vld[d][idx] = 1'b1;
    end else begin
      exp_data = model_mem[d][idx];
      known    = model_vld[d][idx];
    end
  endtask

  // One access on instance d, issued at a negedge where the slave is ready;
  // returns at the negedge inside the RESP cycle.
  task automatic applyStimulus(input int d, input bit wr, input bit rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask, input string tag);
    logic        e_err;
    logic [31:0] e_data;
    bit          known;
    checkOutput({tag, " ready"}, 32'(hready_s[d]), 32'd1);
    wr_s[d] = wr; rd_s[d] = rd; addr_s[d] = addr; wdata_s[d] = data; mask_s[d] = mask;
    model_access(d, wr, addr, data, mask, e_err, e_data, known);
    @(negedge clk);
    wr_s[d] = 1'b0; rd_s[d] = 1'b0;
    addr_s[d] = $urandom; wdata_s[d] = $urandom; mask_s[d] = 4'($urandom);
    for (int k = 0; k < ws_of(d); k++) begin
      checkOutput({tag, " wait hready"}, 32'(hready_s[d]), 32'd0);
      checkOutput({tag, " wait dmdata"}, rdata_s[d], 32'd0);
      @(negedge clk);
    end
    checkOutput({tag, " resp hready"}, 32'(hready_s[d]), 32'd1);
    checkOutput({tag, " resp herr"}, 32'(herr_s[d]), 32'(e_err));
    if (known) checkOutput({tag, " resp dmdata"}, rdata_s[d], e_data);
  endtask

  task automatic idleCycle(input int d, input string tag);
    @(negedge clk);
    checkOutput({tag, " idle hready"}, 32'(hready_s[d]), 32'd1);
    checkOutput({tag, " idle dmdata"}, rdata_s[d], 32'd0);
    checkOutput({tag, " idle herr"}, 32'(herr_s[d]), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int sel;
    logic [31:0] w;
    sel = $urandom_range(0, 9);
    if (sel < 7)      w = 32'($urandom_range(0, 15));
    else if (sel < 9) w = 32'd1024 + 32'($urandom_range(0, 15));
    else              w = 32'd0 - 32'($urandom_range(1, 4));
    return base_of(d) + (w << 2) + 32'($urandom_range(0, 3));
  endfunction

  // Directed scenarios followed by a randomized run on all instances.
  initial begin
`ifdef MSRV32_DMEM_BOUNDS_CHK_EN
    bounds_chk = 1'b1;
`else
    bounds_chk = 1'b0;
`endif
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; addr_s[d] = 32'd0; wdata_s[d] = 32'd0;
      mask_s[d] = 4'd0; wr_s[d] = 1'b0; rd_s[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset hready", 32'(hready_s[d]), 32'd1);
      checkOutput("reset herr", 32'(herr_s[d]), 32'd0);
      checkOutput("reset dmdata", rdata_s[d], 32'd0);
      rst_n[d] = 1'b1;
    end

    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++)
        applyStimulus(d, 1'b1, 1'b0, base_of(d) + 32'(w * 4), $urandom, 4'hF, "fill");
      idleCycle(d, "fill");
    end

    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, "t2 wr");
    idleCycle(1, "t2");
    applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "t2 rd");
    checkOutput("t2 data", rdata_s[1], 32'hDEADBEEF);
    idleCycle(1, "t2");

    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h11223344, 4'b0101, "t3 wr");
    applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "t3 rd");
    checkOutput("t3 data", rdata_s[1], 32'hDE22BE44);
    idleCycle(1, "t3");

    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'hA5A5A5A5, 4'hF, "t4 wr");
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, "t4 rd");
    checkOutput("t4 data", rdata_s[0], 32'hA5A5A5A5);
    idleCycle(0, "t4");

    applyStimulus(1, 1'b1, 1'b0, 32'h1000, 32'h12345678, 4'hF, "t5 wr");
    checkOutput("t5 herr", 32'(herr_s[1]), 32'(bounds_chk));
    applyStimulus(1, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, "t5 rd");
    idleCycle(1, "t5");

    applyStimulus(2, 1'b1, 1'b1, 32'h8000_000C, 32'h0BADF00D, 4'b0000, "mask0");
    applyStimulus(2, 1'b0, 1'b1, 32'h8000_000C, 32'h0, 4'h0, "mask0 rd");
    idleCycle(2, "mask0");

    wr_s[2] = 1'b1; addr_s[2] = 32'h8000_000C; wdata_s[2] = 32'hCAFEF00D; mask_s[2] = 4'hF;
    @(negedge clk);
    wr_s[2] = 1'b0;
    checkOutput("t6 wait hready", 32'(hready_s[2]), 32'd0);
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    checkOutput("t6 rst hready", 32'(hready_s[2]), 32'd1);
    checkOutput("t6 rst dmdata", rdata_s[2], 32'd0);
    idleCycle(2, "t6");
    idleCycle(2, "t6");
    idleCycle(2, "t6");
    applyStimulus(2, 1'b0, 1'b1, 32'h8000_000C, 32'h0, 4'h0, "t6 rd");
    idleCycle(2, "t6");

    for (int it = 0; it < 300; it++) begin
      int d;
      int kind;
      d    = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      applyStimulus(d, (kind < 2) || (kind == 3), kind >= 2, rand_addr(d),
                    $urandom, 4'($urandom), "rand");
      if ($urandom_range(0, 2) == 0) idleCycle(d, "rand");
    end
    for (int d = 0; d < 3; d++) idleCycle(d, "end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
